mem_bus_master: RTL and testbench
=================================

Name: mem_bus_master

Overview:
- CPU-side initiator for the addr/byte_m/mem_op/ready memory interface.
- Drives the memory router or responder from the CPU core.
- Turns one CPU access into one or two memory transactions:
  - aligned word or byte access: one transaction;
  - unaligned word access: two byte transactions.
- Merges the returned data, enforces the mem_op handshake and guards against a hung responder with a timeout.

Parameters:
- TIMEOUT, 1023: cycles to wait for ready per transaction before aborting; must be ≥1.
- TO_W, 10: timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- cpu_clk  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  access request; sampled only in IDLE
- cpu_addr  in  20  byte address
- cpu_we  in  1  1 = write, 0 = read
- cpu_byte  in  1  1 = byte access, 0 = word access
- cpu_wr_data  in  16  write data; byte writes use [7:0]
- cpu_rd_data  out  16  read result; valid while cpu_done = 1
- cpu_done  out  1  one-cycle completion pulse
- cpu_err  out  1  qualifies cpu_done; 1 = timeout abort
- cpu_busy  out  1  high from acceptance through cpu_done
- addr  out  20  memory address
- wr_data  out  16  memory write data
- we  out  1  memory write strobe
- byte_m  out  1  memory byte mode
- mem_op  out  1  transaction request
- rd_data  in  16  memory read data; byte reads return in [7:0]
- ready  in  1  responder completion; may be combinationally high in the same cycle mem_op rises

Behaviour:
- All outputs are registered.
- Reset values: mem_op = 0, we = 0, byte_m = 0, addr = 0, wr_data = 0, cpu_done = 0, cpu_err = 0, cpu_busy = 0, cpu_rd_data = 0, state = IDLE.
- Handshake rules:
  - A transaction completes on the first cpu_clk edge where mem_op & ready.
  - addr, wr_data, we and byte_m are held stable while mem_op = 1.
  - mem_op drops on the edge after completion and stays low for exactly one GAP cycle before any next transaction.
- Request classification at acceptance (IDLE & cpu_req):
  - SINGLE when cpu_byte = 1, or cpu_addr[0] = 0.
  - SPLIT when cpu_byte = 0 and cpu_addr[0] = 1.
- States and transitions:
  - IDLE: on cpu_req, latch the request, set cpu_busy, go to REQ1.
  - REQ1: mem_op = 1.
    - byte_m = 1 for byte accesses and for SPLIT; 0 for aligned words.
    - addr = cpu_addr.
    - wr_data = cpu_wr_data for aligned words; {8'h00, cpu_wr_data[7:0]} for bytes and SPLIT.
    - On completion, capture rd_data[15:0] (aligned word) or rd_data[7:0] (byte/SPLIT). Then SINGLE → DONE; SPLIT → GAP.
  - GAP: mem_op = 0 for one cycle, then → REQ2.
  - REQ2: byte_m = 1; addr = cpu_addr + 1 with 20-bit wrap (FFFFF → 00000); wr_data = {8'h00, cpu_wr_data[15:8]}. On completion, capture rd_data[7:0] as the high byte, go to DONE.
  - DONE: cpu_done = 1 for one cycle, cpu_busy = 0 on exit, → IDLE. A cpu_req asserted during DONE is not accepted; the next acceptance is from IDLE.
- Read result format:
  - byte read: cpu_rd_data = {8'h00, byte}.
  - SPLIT read: cpu_rd_data = {high byte, low byte}.
  - cpu_rd_data holds its value until the next cpu_done.
  - Writes leave cpu_rd_data unchanged.
- Latency, with ready already high:
  - Aligned access: cpu_req sampled at edge 0, mem_op high during cycle 1, cpu_done high during cycle 2.
  - SPLIT access: cpu_done high during cycle 4.
- Timeout:
  - The counter clears on entry to REQ1 or REQ2 and increments each cycle mem_op & !ready.
  - When it reaches TIMEOUT: mem_op drops, cpu_done = 1 with cpu_err = 1, cpu_rd_data = 16'hFFFF, and any remaining SPLIT half is skipped.
- cpu_req while busy is ignored; there is no queueing, and the CPU re-asserts.
- Reset mid-transaction: at the reset edge all outputs return to reset values and cpu_done is not pulsed.

Decomposition:
- Shared package mem_bus_pkg holds:
  - state enum: IDLE, REQ1, GAP, REQ2, DONE;
  - ERR_DATA = 16'hFFFF;
  - ADDR_W = 20.
- One natural sub-module, mem_timeout_cnt:
  - inputs: clear, count enable;
  - output: expired, at TIMEOUT.

Test Plan:
- Aligned word read, addr 0xF0000, ready tied 1, rd_data = 16'hBEEF → one transaction with byte_m = 0; cpu_done during cycle 2; cpu_rd_data = 16'hBEEF.
- Byte write, addr 0x00013, wr 16'h12AB, ready after 3 wait cycles → one transaction with byte_m = 1, we = 1, wr_data = 16'h00AB; cpu_done the cycle after ready.
- Unaligned word read, addr 0xFFFFF, responder returns 8'h34 then 8'h12:
  - REQ1 addr = 0xFFFFF;
  - one mem_op-low cycle;
  - REQ2 addr = 0x00000;
  - cpu_rd_data = 16'h1234.
- Unaligned word write, addr 0xC0001, data 16'hA55A → two byte writes: 0x5A to 0xC0001, then 0xA5 to 0xC0002.
- Timeout: TIMEOUT = 8, ready held 0 → mem_op drops after 8 waiting cycles; cpu_done = 1, cpu_err = 1, cpu_rd_data = 16'hFFFF.
- Reset asserted in REQ2 of a SPLIT read → next edge mem_op = 0, cpu_busy = 0, no cpu_done pulse; a new request after reset completes normally.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the CPU-side memory bus master.
// Holds the FSM state enum, the address width and the abort read value.
package mem_bus_pkg;

    localparam int ADDR_W = 20;
    localparam logic [15:0] ERR_DATA = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        REQ1,
        GAP,
        REQ2,
        DONE
    } state_t;

endpackage

// File: rtl/mem_bus_master_if.sv
// Memory-side bus between the master and a router or responder.
// master: drives addr/wr_data/we/byte_m/mem_op; slave: drives rd_data/ready.
interface mem_bus_master_if;
    import mem_bus_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [15:0]       wr_data;
    logic              we;
    logic              byte_m;
    logic              mem_op;
    logic [15:0]       rd_data;
    logic              ready;

    modport master (
        output addr, wr_data, we, byte_m, mem_op,
        input  rd_data, ready
    );

    modport slave (
        input  addr, wr_data, we, byte_m, mem_op,
        output rd_data, ready
    );

endinterface

// File: rtl/mem_timeout_cnt.sv
// Wait-cycle counter for one bus transaction.
// Ports: clk, reset, clear, en (waiting cycle), expired (this wait hits TIMEOUT).
module mem_timeout_cnt #(
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TO_W'(1);
        end
    end

    // Flags the waiting cycle whose increment brings the count to TIMEOUT,
    // so mem_op is high for exactly TIMEOUT waiting cycles before abort.
    assign expired = en && (cnt == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_master.sv
// CPU-side initiator: one CPU access becomes one or two bus transactions.
// Ports: cpu_clk, reset, cpu_req/addr/we/byte/wr_data in, cpu_rd_data/done/err/busy out, bus (master).
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input  logic              cpu_clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic              cpu_byte,
    input  logic [15:0]       cpu_wr_data,
    output logic [15:0]       cpu_rd_data,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic              cpu_busy,
    mem_bus_master_if.master  bus
);

    state_t state, state_n;

    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [15:0]       wd_q, wd_n;
    logic              we_q, we_n;
    logic              bm_q, bm_n;
    logic              op_q, op_n;
    logic              done_q, done_n;
    logic              err_q, err_n;
    logic              busy_q, busy_n;
    logic [15:0]       rdd_q, rdd_n;
    logic [7:0]        lo_q, lo_n;

    logic [ADDR_W-1:0] req_addr, ra_n;
    logic [15:0]       req_wd, rw_n;
    logic              req_we, rwe_n;
    logic              req_split, rs_n;

    logic narrow;
    logic hit;
    logic expired;
    logic to_clear;

    // Byte accesses and both halves of an unaligned word use byte mode.
    assign narrow   = cpu_byte | cpu_addr[0];
    assign hit      = op_q & bus.ready;
    assign to_clear = (state != REQ1) && (state != REQ2);

    mem_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_to (
        .clk     (cpu_clk),
        .reset   (reset),
        .clear   (to_clear),
        .en      (op_q & ~bus.ready),
        .expired (expired)
    );

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        op_n    = op_q;
        addr_n  = addr_q;
        wd_n    = wd_q;
        we_n    = we_q;
        bm_n    = bm_q;
        done_n  = 1'b0;
        err_n   = 1'b0;
        busy_n  = busy_q;
        rdd_n   = rdd_q;
        lo_n    = lo_q;
        ra_n    = req_addr;
        rw_n    = req_wd;
        rwe_n   = req_we;
        rs_n    = req_split;
        unique case (state)
            IDLE: begin
                if (cpu_req) begin
                    state_n = REQ1;
                    busy_n  = 1'b1;
                    op_n    = 1'b1;
                    addr_n  = cpu_addr;
                    we_n    = cpu_we;
                    bm_n    = narrow;
                    wd_n    = narrow ? {8'h00, cpu_wr_data[7:0]}
                                     : cpu_wr_data;
                    ra_n    = cpu_addr;
                    rw_n    = cpu_wr_data;
                    rwe_n   = cpu_we;
                    rs_n    = ~cpu_byte & cpu_addr[0];
                end
            end
            REQ1: begin
                if (hit) begin
                    op_n = 1'b0;
                    if (req_split) begin
                        state_n = GAP;
                        lo_n    = bus.rd_data[7:0];
                    end else begin
                        state_n = DONE;
                        done_n  = 1'b1;
                        if (!req_we) begin
                            rdd_n = bm_q ? {8'h00, bus.rd_data[7:0]}
                                         : bus.rd_data;
                        end
                    end
                end else if (expired) begin
                    op_n    = 1'b0;
                    state_n = DONE;
                    done_n  = 1'b1;
                    err_n   = 1'b1;
                    rdd_n   = ERR_DATA;
                end
            end
            GAP: begin
                state_n = REQ2;
                op_n    = 1'b1;
                bm_n    = 1'b1;
                addr_n  = req_addr + ADDR_W'(1);
                wd_n    = {8'h00, req_wd[15:8]};
            end
            REQ2: begin
                if (hit) begin
                    op_n    = 1'b0;
                    state_n = DONE;
                    done_n  = 1'b1;
                    if (!req_we) begin
                        rdd_n = {bus.rd_data[7:0], lo_q};
                    end
                end else if (expired) begin
                    op_n    = 1'b0;
                    state_n = DONE;
                    done_n  = 1'b1;
                    err_n   = 1'b1;
                    rdd_n   = ERR_DATA;
                end
            end
            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            op_q      <= 1'b0;
            addr_q    <= '0;
            wd_q      <= '0;
            we_q      <= 1'b0;
            bm_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            rdd_q     <= '0;
            lo_q      <= '0;
            req_addr  <= '0;
            req_wd    <= '0;
            req_we    <= 1'b0;
            req_split <= 1'b0;
        end else begin
            op_q      <= op_n;
            addr_q    <= addr_n;
            wd_q      <= wd_n;
            we_q      <= we_n;
            bm_q      <= bm_n;
            done_q    <= done_n;
            err_q     <= err_n;
            busy_q    <= busy_n;
            rdd_q     <= rdd_n;
            lo_q      <= lo_n;
            req_addr  <= ra_n;
            req_wd    <= rw_n;
            req_we    <= rwe_n;
            req_split <= rs_n;
        end
    end

    assign bus.mem_op  = op_q;
    assign bus.addr    = addr_q;
    assign bus.wr_data = wd_q;
    assign bus.we      = we_q;
    assign bus.byte_m  = bm_q;
    assign cpu_done    = done_q;
    assign cpu_err     = err_q;
    assign cpu_busy    = busy_q;
    assign cpu_rd_data = rdd_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Scoreboard bench for mem_bus_master: random CPU accesses against a
// byte-addressed reference memory, with a responder modelling wait states.
module tb_mem_bus_master;

    localparam int TIMEOUT = 8;
    localparam int TO_W    = 4;

    typedef struct {
        logic [19:0] addr;
        logic        bm;
        logic        we;
        logic [15:0] wd;
        bit          second;
    } txn_t;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          lat;
    } res_t;

    logic        cpu_clk;
    logic        reset;
    logic        cpu_req;
    logic [19:0] cpu_addr;
    logic        cpu_we;
    logic        cpu_byte;
    logic [15:0] cpu_wr_data;
    logic [15:0] cpu_rd_data;
    logic        cpu_done;
    logic        cpu_err;
    logic        cpu_busy;

    mem_bus_master_if bus();

    mem_bus_master #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .cpu_clk     (cpu_clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_we      (cpu_we),
        .cpu_byte    (cpu_byte),
        .cpu_wr_data (cpu_wr_data),
        .cpu_rd_data (cpu_rd_data),
        .cpu_done    (cpu_done),
        .cpu_err     (cpu_err),
        .cpu_busy    (cpu_busy),
        .bus         (bus)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    int checks = 0;
    int errors = 0;

    txn_t txn_q[$];
    res_t res_q[$];
    int   wait_q[$];

    logic [7:0] bmem [logic [19:0]];
    logic [7:0] rmem [logic [19:0]];
    logic [15:0] last_rd = 16'h0000;

    bit   rst_abort = 0;
    bit   in_req2 = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] brd(logic [19:0] a);
        return bmem.exists(a) ? bmem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] rrd(logic [19:0] a);
        return rmem.exists(a) ? rmem[a] : 8'h00;
    endfunction

    // Responder and bus monitor: ready and rd_data change mid-cycle.
    bit   active = 0;
    bit   completed = 0;
    int   wcnt = 0;
    int   wtgt = 0;
    int   hicnt = 0;
    int   lowcnt = 100;
    txn_t cur;

    always @(negedge cpu_clk) begin
        if (reset) begin
            bus.ready   = 1'b0;
            bus.rd_data = 16'h0000;
            if (active && !completed && !rst_abort) begin
                chk("abort_unexpected", 1, 0);
            end
            active    = 0;
            completed = 0;
            rst_abort = 0;
            lowcnt    = 100;
        end else if (bus.mem_op) begin
            if (!active) begin
                active    = 1;
                completed = 0;
                wcnt      = 0;
                hicnt     = 0;
                chk("txn_avail", txn_q.size() != 0, 1);
                if (txn_q.size() != 0) begin
                    cur = txn_q.pop_front();
                    chk("txn", {bus.addr, bus.byte_m, bus.we, bus.wr_data},
                        {cur.addr, cur.bm, cur.we, cur.wd});
                    if (cur.second) chk("gap_len", lowcnt, 1);
                    in_req2 = cur.second;
                end
                wtgt = (wait_q.size() != 0) ? wait_q.pop_front() : 0;
            end else begin
                chk("bus_stable", {bus.addr, bus.byte_m, bus.we, bus.wr_data},
                    {cur.addr, cur.bm, cur.we, cur.wd});
            end
            hicnt++;
            lowcnt = 0;
            if (wcnt == wtgt) begin
                bus.ready = 1'b1;
                completed = 1;
                if (bus.byte_m)
                    bus.rd_data = {8'($urandom), brd(bus.addr)};
                else
                    bus.rd_data = {brd(bus.addr + 20'd1), brd(bus.addr)};
                if (bus.we) begin
                    bmem[bus.addr] = bus.wr_data[7:0];
                    if (!bus.byte_m) bmem[bus.addr + 20'd1] = bus.wr_data[15:8];
                end
            end else begin
                bus.ready   = 1'b0;
                bus.rd_data = 16'($urandom);
            end
            wcnt++;
        end else begin
            if (active && !completed) begin
                if (rst_abort) rst_abort = 0;
                else chk("timeout_len", hicnt, TIMEOUT);
            end
            active    = 0;
            completed = 0;
            bus.ready = 1'b0;
            lowcnt++;
        end
    end

    // CPU-side monitor: pops expected results on every cpu_done.
    int lat = 0;
    bit prev_done = 0;

    always @(negedge cpu_clk) begin
        if (reset) begin
            lat       = 0;
            prev_done = 0;
        end else begin
            if (cpu_busy) lat++;
            else lat = 0;
            if (prev_done) chk("after_done", {cpu_done, cpu_busy}, 2'b00);
            if (cpu_done) begin
                chk("res_avail", res_q.size() != 0, 1);
                if (res_q.size() != 0) begin
                    res_t e;
                    e = res_q.pop_front();
                    chk("rd_data", cpu_rd_data, e.data);
                    chk("err", cpu_err, e.err);
                    chk("latency", lat, e.lat);
                    chk("busy_at_done", cpu_busy, 1);
                end
            end
            prev_done = cpu_done;
        end
    end

    task automatic issue(logic [19:0] a, bit wr, bit byt, logic [15:0] d,
                         int w1, int w2, bit hang, bit wait_done);
        bit   split;
        bit   nar;
        txn_t t;
        res_t r;
        int   n;
        split = !byt && a[0];
        nar   = byt || a[0];
        wait_q.push_back(hang ? 1000 : w1);
        if (split && !hang) wait_q.push_back(w2);
        t.addr = a; t.bm = nar; t.we = wr; t.second = 0;
        t.wd = nar ? {8'h00, d[7:0]} : d;
        txn_q.push_back(t);
        if (split && !hang) begin
            t.addr = a + 20'd1; t.bm = 1; t.wd = {8'h00, d[15:8]}; t.second = 1;
            txn_q.push_back(t);
        end
        if (hang) begin
            r.data = 16'hFFFF; r.err = 1; r.lat = TIMEOUT + 1;
            last_rd = r.data;
        end else begin
            r.err = 0;
            r.lat = split ? 4 + w1 + w2 : 2 + w1;
            if (wr) begin
                r.data = last_rd;
                rmem[a] = d[7:0];
                if (!byt) rmem[a + 20'd1] = d[15:8];
            end else begin
                r.data = byt ? {8'h00, rrd(a)} : {rrd(a + 20'd1), rrd(a)};
                last_rd = r.data;
            end
        end
        res_q.push_back(r);
        @(negedge cpu_clk);
        cpu_req = 1; cpu_addr = a; cpu_we = wr; cpu_byte = byt; cpu_wr_data = d;
        @(posedge cpu_clk);
        #1;
        cpu_addr = 20'($urandom); cpu_we = 1'($urandom);
        cpu_byte = 1'($urandom); cpu_wr_data = 16'($urandom);
        if (wait_done) begin
            n = 0;
            do begin
                @(negedge cpu_clk);
                n++;
            end while (!cpu_done && n < 200);
            chk("done_seen", cpu_done, 1);
            cpu_req = 0;
        end
    endtask

    function automatic logic [19:0] rand_addr();
        case ($urandom_range(0, 3))
            0: return 20'($urandom_range(0, 31));
            1: return 20'hFFFF0 + 20'($urandom_range(0, 15));
            2: return 20'($urandom);
            default: return 20'h00010 + 20'($urandom_range(0, 7));
        endcase
    endfunction

    initial begin
        int n;
        reset = 1; cpu_req = 0; cpu_addr = 0; cpu_we = 0;
        cpu_byte = 0; cpu_wr_data = 0;
        repeat (3) @(posedge cpu_clk);
        @(negedge cpu_clk);
        chk("rst_mem_op", bus.mem_op, 0);
        chk("rst_we_bm", {bus.we, bus.byte_m}, 2'b00);
        chk("rst_addr", bus.addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_cpu", {cpu_done, cpu_err, cpu_busy}, 3'b000);
        chk("rst_rd_data", cpu_rd_data, 0);
        reset = 0;

        bmem[20'hF0000] = 8'hEF; bmem[20'hF0001] = 8'hBE;
        rmem[20'hF0000] = 8'hEF; rmem[20'hF0001] = 8'hBE;
        bmem[20'hFFFFF] = 8'h34; bmem[20'h00000] = 8'h12;
        rmem[20'hFFFFF] = 8'h34; rmem[20'h00000] = 8'h12;

        issue(20'hF0000, 0, 0, 16'h0000, 0, 0, 0, 1);
        issue(20'h00013, 1, 1, 16'h12AB, 3, 0, 0, 1);
        issue(20'hFFFFF, 0, 0, 16'h0000, 1, 2, 0, 1);
        issue(20'hC0001, 1, 0, 16'hA55A, 0, 1, 0, 1);
        issue(20'hC0001, 0, 0, 16'h0000, 0, 0, 0, 1);
        issue(20'h00040, 0, 0, 16'h0000, 0, 0, 1, 1);
        issue(20'h00041, 1, 0, 16'h7788, 0, 0, 1, 1);

        issue(20'h00021, 0, 0, 16'h0000, 0, 5, 0, 0);
        n = 0;
        do begin
            @(negedge cpu_clk);
            n++;
        end while (!in_req2 && n < 50);
        chk("req2_seen", in_req2, 1);
        reset = 1; cpu_req = 0; rst_abort = 1;
        res_q.delete(); txn_q.delete(); wait_q.delete();
        @(negedge cpu_clk);
        chk("rst_mid_op", {bus.mem_op, cpu_busy, cpu_done}, 3'b000);
        @(negedge cpu_clk);
        reset = 0;
        last_rd = 16'h0000;
        in_req2 = 0;

        issue(20'h00013, 0, 1, 16'h0000, 0, 0, 0, 1);

        for (int i = 0; i < 60; i++) begin
            issue(rand_addr(), 1'($urandom), ($urandom_range(0, 2) == 0),
                  16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 9) == 0), 1);
        end
        repeat (3) @(negedge cpu_clk);

        chk("res_q_empty", res_q.size(), 0);
        chk("txn_q_empty", txn_q.size(), 0);
        foreach (rmem[k]) chk("mem_ref", brd(k), rmem[k]);
        foreach (bmem[k]) chk("mem_bus", rrd(k), bmem[k]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
